// File: rtl/mackey_glass_interp_lut.sv
// Programmable Mackey-Glass nonlinearity: runtime-loaded breakpoint table with
// optional linear interpolation, 3-stage valid/ready pipeline with full backpressure.
module mackey_glass_interp_lut #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_BITS  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    input  logic                  interp_en,
    input  logic                  cfg_we,
    input  logic [ADDR_BITS:0]    cfg_addr,
    input  logic [OUT_WIDTH-1:0]  cfg_data
);

    localparam int FRAC_BITS = DATA_WIDTH - ADDR_BITS;
    localparam int TBL_N     = (1 << ADDR_BITS) + 1;
    localparam int PROD_W    = OUT_WIDTH + FRAC_BITS + 1;
    localparam logic [ADDR_BITS:0] LAST_IDX = {1'b1, {ADDR_BITS{1'b0}}};

    logic [OUT_WIDTH-1:0] tbl_q [TBL_N];

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_ie_q, s1_ie_d;
    logic [FRAC_BITS-1:0]    s1_frac_q, s1_frac_d;
    logic [OUT_WIDTH-1:0]    s1_t0_q, s1_t0_d;
    logic [OUT_WIDTH-1:0]    s1_t1_q, s1_t1_d;

    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_ie_q, s2_ie_d;
    logic [OUT_WIDTH-1:0]    s2_t0_q, s2_t0_d;
    logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d;

    logic                    out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;

    logic                    adv;
    logic [ADDR_BITS:0]      rd_idx0, rd_idx1;
    logic signed [OUT_WIDTH:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_WIDTH-1:0]    y;
    logic                    unused_prod_bits;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // i+1 never exceeds the last breakpoint, so no wrap handling is needed.
    assign rd_idx0 = {1'b0, in_data[DATA_WIDTH-1 -: ADDR_BITS]};
    assign rd_idx1 = rd_idx0 + {{ADDR_BITS{1'b0}}, 1'b1};

    // NOTE: the table is a flop array cleared by reset, not a RAM, so reset wipes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TBL_N; k++) tbl_q[k] <= '0;
        end else if (cfg_we && (cfg_addr <= LAST_IDX)) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        diff = $signed({1'b0, s1_t1_q}) - $signed({1'b0, s1_t0_q});
        prod = $signed({{(PROD_W-OUT_WIDTH-1){diff[OUT_WIDTH]}}, diff})
             * $signed({{(PROD_W-FRAC_BITS){1'b0}}, s1_frac_q});
    end

    // Low OUT_WIDTH bits of (p >>> FRAC_BITS) are exactly this slice; the result
    // is known to lie between T[i] and T[i+1], so modular addition is exact.
    assign y = s2_ie_q ? (s2_t0_q + s2_prod_q[FRAC_BITS +: OUT_WIDTH]) : s2_t0_q;
    assign unused_prod_bits = ^{s2_prod_q[PROD_W-1], s2_prod_q[FRAC_BITS-1:0]};

    // NOTE: every next-state signal defaults to its current value first, so no latches.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ie_d     = s1_ie_q;
        s1_frac_d   = s1_frac_q;
        s1_t0_d     = s1_t0_q;
        s1_t1_d     = s1_t1_q;
        s2_valid_d  = s2_valid_q;
        s2_ie_d     = s2_ie_q;
        s2_t0_d     = s2_t0_q;
        s2_prod_d   = s2_prod_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_ie_d     = interp_en;
            s1_frac_d   = in_data[FRAC_BITS-1:0];
            s1_t0_d     = tbl_q[rd_idx0];
            s1_t1_d     = tbl_q[rd_idx1];
            s2_valid_d  = s1_valid_q;
            s2_ie_d     = s1_ie_q;
            s2_t0_d     = s1_t0_q;
            s2_prod_d   = prod;
            out_valid_d = s2_valid_q;
            if (s2_valid_q) out_data_d = y;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ie_q     <= 1'b0;
            s1_frac_q   <= '0;
            s1_t0_q     <= '0;
            s1_t1_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_ie_q     <= 1'b0;
            s2_t0_q     <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ie_q     <= s1_ie_d;
            s1_frac_q   <= s1_frac_d;
            s1_t0_q     <= s1_t0_d;
            s1_t1_q     <= s1_t1_d;
            s2_valid_q  <= s2_valid_d;
            s2_ie_q     <= s2_ie_d;
            s2_t0_q     <= s2_t0_d;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mackey_glass_interp_lut.sv
// Self-checking bench: directed literal cases plus randomized streaming against
// a behavioural table/interpolation model and an in-order scoreboard.
module tb_mackey_glass_interp_lut;

    localparam int DW = 16;
    localparam int OW = 16;
    localparam int AB = 7;
    localparam int NT = (1 << AB) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          interp_en = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AB:0]   cfg_addr = '0;
    logic [OW-1:0] cfg_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int mtbl[NT];
    int sb[$];
    bit stall_prev = 1'b0;
    logic [OW-1:0] held = '0;

    always #5 clk = ~clk;

    mackey_glass_interp_lut #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .interp_en(interp_en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // f(x) from the breakpoint rules with plain integer math and floor division.
    function automatic int ref_f(input int x, input bit ie);
        int i, f, a, b, num, q;
        i = x / 512;
        f = x % 512;
        a = mtbl[i];
        b = mtbl[i+1];
        if (!ie) return a;
        num = (b - a) * f;
        q = num / 512;
        if (num < 0 && (num % 512) != 0) q = q - 1;
        return (a + q) & 32'hFFFF;
    endfunction

    // Monitor at the falling edge: signals are stable for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            for (int k = 0; k < NT; k++) mtbl[k] = 0;
            stall_prev = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (stall_prev && out_valid) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_output", 0, 1);
                else check("stream_data", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(ref_f(int'(in_data), interp_en));
            if (cfg_we && cfg_addr <= 8'd128) mtbl[cfg_addr] = int'(cfg_data);
            stall_prev = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = addr[AB:0];
        cfg_data = data[OW-1:0];
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp);
        int t = 0;
        while (!out_valid && t < 10) begin
            tick();
            t++;
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
        else check(name, out_data, exp);
        tick();
    endtask

    task automatic run_one(input int x, input bit ie, input int exp, input string name);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = x[DW-1:0];
        interp_en = ie;
        tick();
        in_valid = 1'b0;
        wait_result(name, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_exp[8];
        int bp_exp[3];
        int t;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);

        // Linear table T[k] = 16k.
        for (int k = 0; k < NT; k++) write_tbl(k, 16 * k);
        run_one('h0000, 1'b1, 0,    "lin_0000");
        run_one('h0100, 1'b1, 8,    "lin_0100");
        run_one('hFFFF, 1'b1, 2047, "lin_ffff");
        run_one('h1234, 1'b1, 145,  "lin_1234");
        run_one('h1234, 1'b0, 144,  "zoh_1234");
        run_one('hFFFF, 1'b0, 2032, "zoh_ffff");

        write_tbl(5, 1000);
        write_tbl(6, 200);
        run_one('h0B00, 1'b1, 600, "desc_f256");
        run_one('h0BFF, 1'b1, 201, "desc_f511");

        // A sample presented in cycle n shows out_valid in cycle n+3.
        out_ready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            if (s < 8) begin
                in_valid = 1'b1;
                in_data = DW'($urandom);
                interp_en = 1'($urandom);
                lat_exp[s] = ref_f(int'(in_data), interp_en);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (s < 2) begin
                check("lat_early_valid", out_valid, 0);
            end else begin
                check("lat_stream_valid", out_valid, 1);
                check("lat_stream_data", out_data, lat_exp[s-2]);
            end
        end
        tick();
        check("lat_end_valid", out_valid, 0);

        // Backpressure: three samples then a five-cycle stall.
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            interp_en = 1'b1;
            bp_exp[s] = ref_f(int'(in_data), 1'b1);
            tick();
        end
        in_valid = 1'b0;
        check("bp_first_valid", out_valid, 1);
        check("bp_first_data", out_data, bp_exp[0]);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_data", out_data, bp_exp[0]);
        end
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("bp_release_valid", out_valid, 1);
            check("bp_release_data", out_data, bp_exp[s]);
            tick();
        end
        check("bp_drained", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);

        // Reset with two samples in flight.
        in_valid = 1'b1;
        in_data = 16'h4321;
        interp_en = 1'b1;
        tick();
        in_data = 16'h8765;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_out_valid", out_valid, 0);
        run_one(int'($urandom_range(0, 65535)), 1'b1, 0, "empty_table");

        // Write T[128] on the same edge as the sample's stage-1 read.
        write_tbl(127, 100);
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        interp_en = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 8'd128;
        cfg_data = 16'd1100;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b0;
        wait_result("same_edge_old", 0);
        run_one('hFFFF, 1'b1, 1098, "after_write");
        write_tbl(200, 'hABCD);
        run_one(72 * 512, 1'b0, 0, "ignored_write");

        // Randomized streaming with random table, writes, backpressure and a reset.
        for (int k = 0; k < NT; k++) write_tbl(k, int'($urandom_range(0, 65535)));
        for (int c = 0; c < 1800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom);
            interp_en = 1'($urandom);
            out_ready = (c >= 1400) ? c[0] : ($urandom_range(0, 2) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = 8'($urandom);
            cfg_data = OW'($urandom);
            if (c == 700) rst = 1'b1;
            if (c == 701) rst = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        rst = 1'b0;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 50) begin
            tick();
            t++;
        end
        check("drain_scoreboard", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
